// File: rtl/spram_zxn_pkg.sv
// rtl/spram_zxn_pkg.sv - shared constants and types for the spram_zxn arbiter
// Contents:
//   PORT_CPU / PORT_DMA : requester indices, also bit positions in grant vectors
//   LAST_RST            : reset value of the round-robin pointer (port 0 wins first)
//   grant_tag_t         : return-path tag {valid, port}
package spram_zxn_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Pointer names the last winner; starting at DMA hands the first tie to CPU.
    localparam logic LAST_RST = PORT_DMA;

    typedef struct packed {
        logic valid;
        logic port;
    } grant_tag_t;

endpackage

// File: rtl/spram_zxn.sv
// rtl/spram_zxn.sv - single-port synchronous RAM with registered write-through output
// Ports:
//   clocka    in  1          rising-edge clock
//   address_a in  ADDRWIDTH  address
//   data_a    in  DATAWIDTH  write data
//   wren_a    in  1          write enable
//   q_a       out DATAWIDTH  registered read data (write data on a write)
module spram_zxn #(
    parameter int DATAWIDTH      = 8,
    parameter int ADDRWIDTH      = 8,
    parameter int FILL_REMAINING = 0
) (
    input  logic                 clocka,
    input  logic [ADDRWIDTH-1:0] address_a,
    input  logic [DATAWIDTH-1:0] data_a,
    input  logic                 wren_a,
    output logic [DATAWIDTH-1:0] q_a
);

    logic [DATAWIDTH-1:0] mem [0:(1<<ADDRWIDTH)-1];

    // Contents are not initialised in this model; the parameter is kept for
    // drop-in compatibility with the vendor RAM.
    logic unused_fill;
    assign unused_fill = (FILL_REMAINING != 0);

    always_ff @(posedge clocka) begin
        if (wren_a) begin
            mem[address_a] <= data_a;
            q_a            <= data_a;
        end else begin
            q_a            <= mem[address_a];
        end
    end

endmodule

// File: rtl/spram_zxn_rr2.sv
// rtl/spram_zxn_rr2.sv - two-input round-robin (or fixed-priority) arbiter
// Ports:
//   req   in  [1:0]  request per port
//   last  in  1      last granted port (round-robin pointer)
//   grant out [1:0]  one-hot grant
//   any   out 1      some port granted this cycle
// Build option: SPRAM_ARB_FIXED_PRIO_EN selects absolute priority for port 0.
module spram_zxn_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       any
);

`ifdef SPRAM_ARB_FIXED_PRIO_EN
    // Pointer has no role here; tie it off visibly.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            // Tie goes to the port that did not win last.
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end
`endif

    assign any = |req;

endmodule

// File: rtl/spram_zxn_arb.sv
// rtl/spram_zxn_arb.sv - two-requester arbiter in front of spram_zxn
// Ports:
//   clocka, rst_n                      clock, async active-low reset
//   req/we/addr/wdata 0,1              requester inputs (req held until ack)
//   ack 0,1                            1-cycle accept pulse, cycle after grant
//   rvalid 0,1 / rdata 0,1             return strobe two cycles after grant; data = ram_q
//   ram_addr/ram_wdata/ram_wren/ram_q  RAM port
// Build option: SPRAM_ARB_FIXED_PRIO_EN (see spram_zxn_rr2).
module spram_zxn_arb
    import spram_zxn_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 8
) (
    input  logic                 clocka,
    input  logic                 rst_n,

    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDRWIDTH-1:0] addr0,
    input  logic [DATAWIDTH-1:0] wdata0,
    output logic                 ack0,
    output logic                 rvalid0,
    output logic [DATAWIDTH-1:0] rdata0,

    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDRWIDTH-1:0] addr1,
    input  logic [DATAWIDTH-1:0] wdata1,
    output logic                 ack1,
    output logic                 rvalid1,
    output logic [DATAWIDTH-1:0] rdata1,

    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_wdata,
    output logic                 ram_wren,
    input  logic [DATAWIDTH-1:0] ram_q
);

    logic [1:0] grant;
    logic       any;
    logic       last;
    grant_tag_t tag_s1;
    grant_tag_t tag_s2;

    spram_zxn_rr2 u_rr2 (
        .req   ({req1, req0}),
        .last  (last),
        .grant (grant),
        .any   (any)
    );

    always_ff @(posedge clocka or negedge rst_n) begin
        if (!rst_n) begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
            last      <= LAST_RST;
            tag_s1    <= '0;
            tag_s2    <= '0;
        end else begin
            ack0     <= grant[PORT_CPU];
            ack1     <= grant[PORT_DMA];
            ram_wren <= 1'b0;
            if (grant[PORT_CPU]) begin
                ram_addr  <= addr0;
                ram_wdata <= wdata0;
                ram_wren  <= we0;
            end else if (grant[PORT_DMA]) begin
                ram_addr  <= addr1;
                ram_wdata <= wdata1;
                ram_wren  <= we1;
            end
            if (any) begin
                last <= grant[PORT_DMA];
            end
            // Stage 1 lines up with the RAM access cycle, stage 2 with ram_q.
            tag_s1.valid <= any;
            tag_s1.port  <= grant[PORT_DMA];
            tag_s2       <= tag_s1;
        end
    end

    assign rvalid0 = tag_s2.valid && (tag_s2.port == PORT_CPU);
    assign rvalid1 = tag_s2.valid && (tag_s2.port == PORT_DMA);
    assign rdata0  = ram_q;
    assign rdata1  = ram_q;

endmodule

// File: tb/tb_spram_zxn_arb.sv
// tb/tb_spram_zxn_arb.sv - directed self-checking bench for spram_zxn_arb with spram_zxn
module tb_spram_zxn_arb;

    logic       clocka = 1'b0;
    logic       rst_n  = 1'b0;
    logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic       ack0, rvalid0, ack1, rvalid1, ram_wren;
    logic [7:0] rdata0, rdata1, ram_addr, ram_wdata, ram_q;

    int checks = 0;
    int errors = 0;
    logic [7:0] model [0:255];

    spram_zxn_arb #(.DATAWIDTH(8), .ADDRWIDTH(8)) dut (
        .clocka(clocka), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    spram_zxn #(.DATAWIDTH(8), .ADDRWIDTH(8), .FILL_REMAINING(0)) u_ram (
        .clocka(clocka), .address_a(ram_addr), .data_a(ram_wdata),
        .wren_a(ram_wren), .q_a(ram_q)
    );

    always #5 clocka = ~clocka;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Port 0 held for n cycles, address stepping base..base+n-1 each cycle.
    task automatic burst0(input logic we, input int n, input logic [7:0] base);
        req0 = 1'b1; we0 = we; addr0 = base; wdata0 = model[base];
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clocka);
            chk("burst_ack0", ack0, (k - 1 < n));
            chk("burst_ack1", ack1, 0);
            if (k - 1 < n) begin
                chk("burst_addr", ram_addr, base + 8'(k - 1));
                chk("burst_wren", ram_wren, we);
            end
            chk("burst_rvalid0", rvalid0, (k >= 2));
            if (k >= 2) chk("burst_rdata0", rdata0, model[base + 8'(k - 2)]);
            if (k < n) begin
                addr0 = base + 8'(k); wdata0 = model[base + 8'(k)];
            end else begin
                req0 = 1'b0; we0 = 1'b0;
            end
        end
        @(negedge clocka);
        chk("burst_drain", rvalid0, 0);
    endtask

    initial begin
        logic exp_g;
        model[8'h00] = 8'h11; model[8'h01] = 8'h22;
        model[8'h02] = 8'h33; model[8'h03] = 8'h44;
        model[8'h12] = 8'hA5;

        // Reset state
        @(negedge clocka);
        chk("rst_ack0", ack0, 0);       chk("rst_ack1", ack1, 0);
        chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
        chk("rst_wren", ram_wren, 0);   chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        @(negedge clocka);
        rst_n = 1'b1;
        @(negedge clocka);

        // Port 0 write 0x12 <= 0xA5
        req0 = 1; we0 = 1; addr0 = 8'h12; wdata0 = 8'hA5;
        @(negedge clocka);
        chk("w_ack0", ack0, 1); chk("w_ack1", ack1, 0);
        chk("w_wren", ram_wren, 1); chk("w_addr", ram_addr, 8'h12);
        chk("w_wdata", ram_wdata, 8'hA5);
        req0 = 0; we0 = 0;
        @(negedge clocka);
        chk("w_rvalid0", rvalid0, 1); chk("w_rdata0", rdata0, 8'hA5);
        chk("w_rvalid1", rvalid1, 0); chk("w_ack0_once", ack0, 0);
        chk("w_wren_off", ram_wren, 0);
        @(negedge clocka);

        // Preload 0x00..0x03 with a back-to-back port 0 write burst
        burst0(1'b1, 4, 8'h00);

        // Port 1 read of 0x12
        req1 = 1; we1 = 0; addr1 = 8'h12;
        @(negedge clocka);
        chk("r1_ack1", ack1, 1); chk("r1_ack0", ack0, 0); chk("r1_wren", ram_wren, 0);
        req1 = 0;
        @(negedge clocka);
        chk("r1_rvalid1", rvalid1, 1); chk("r1_rdata1", rdata1, 8'hA5);
        chk("r1_rvalid0", rvalid0, 0);
        @(negedge clocka);

        // Contention: both read for 8 cycles, port 0 from 0x00, port 1 from 0x01
        req0 = 1; we0 = 0; addr0 = 8'h00;
        req1 = 1; we1 = 0; addr1 = 8'h01;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clocka);
            if (k == 8) begin req0 = 0; req1 = 0; end
`ifdef SPRAM_ARB_FIXED_PRIO_EN
            exp_g = 1'b0;
`else
            exp_g = 1'((k - 1) % 2);
`endif
            chk("cont_ack0", ack0, (k - 1 < 8) && !exp_g);
            chk("cont_ack1", ack1, (k - 1 < 8) && exp_g);
            if (k >= 2) begin
`ifdef SPRAM_ARB_FIXED_PRIO_EN
                exp_g = 1'b0;
`else
                exp_g = 1'((k - 2) % 2);
`endif
                chk("cont_rvalid0", rvalid0, !exp_g);
                chk("cont_rvalid1", rvalid1, exp_g);
                chk("cont_rdata", ram_q, exp_g ? 8'h22 : 8'h11);
            end
        end
        @(negedge clocka);
        chk("cont_idle0", rvalid0, 0); chk("cont_idle1", rvalid1, 0);

        // Port 0 alone, reads 0..3 back to back
        burst0(1'b0, 4, 8'h00);

        // Reset the cycle after a read grant
        req0 = 1; we0 = 0; addr0 = 8'h02;
        @(negedge clocka);
        chk("rr_ack0", ack0, 1);
        rst_n = 0; req0 = 0;
        #1;
        chk("rr_ack0_clr", ack0, 0);   chk("rr_ack1_clr", ack1, 0);
        chk("rr_rvalid0", rvalid0, 0); chk("rr_rvalid1", rvalid1, 0);
        chk("rr_wren", ram_wren, 0);   chk("rr_addr", ram_addr, 0);
        chk("rr_wdata", ram_wdata, 0);
        @(negedge clocka);
        rst_n = 1;
        @(negedge clocka);
        chk("rr_post_rvalid0", rvalid0, 0); chk("rr_post_rvalid1", rvalid1, 0);
        @(negedge clocka);
        chk("rr_post2_rvalid0", rvalid0, 0);

        // First post-reset contention goes to port 0
        req0 = 1; addr0 = 8'h00; req1 = 1; addr1 = 8'h01;
        @(negedge clocka);
        chk("pr_ack0", ack0, 1); chk("pr_ack1", ack1, 0);
        req0 = 0;
        @(negedge clocka);
        chk("pr_ack1_next", ack1, 1); chk("pr_ack0_next", ack0, 0);
        chk("pr_rvalid0", rvalid0, 1); chk("pr_rdata0", rdata0, 8'h11);
        req1 = 0;
        @(negedge clocka);
        chk("pr_rvalid1", rvalid1, 1); chk("pr_rdata1", rdata1, 8'h22);
        @(negedge clocka);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
